// File: rtl/mem_arbiter.sv
// Two-port (I/D cache) arbiter onto a single slow line-memory port.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise D wins.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_I,
    input  logic              mem_write_I,
    input  logic [ADDR_W-1:0] mem_addr_I,
    input  logic [LINE_W-1:0] mem_wdata_I,
    output logic [LINE_W-1:0] mem_rdata_I,
    output logic              mem_ready_I,
    input  logic              mem_read_D,
    input  logic              mem_write_D,
    input  logic [ADDR_W-1:0] mem_addr_D,
    input  logic [LINE_W-1:0] mem_wdata_D,
    output logic [LINE_W-1:0] mem_rdata_D,
    output logic              mem_ready_D,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    state_t state;
    logic   req_i;
    logic   req_d;
    logic   pick_d;

    assign req_i = mem_read_I | mem_write_I;
    assign req_d = mem_read_D | mem_write_D;

`ifdef MEM_ARB_RR_EN
    logic last_d;
    // On a tie, D wins only if I was served last.
    assign pick_d = req_d & (~req_i | ~last_d);
`else
    assign pick_d = req_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_rdata_I <= '0;
            mem_rdata_D <= '0;
            mem_ready_I <= 1'b0;
            mem_ready_D <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_d      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_d) begin
                        state     <= BUSY_D;
                        mem_write <= mem_write_D;
                        mem_read  <= mem_read_D & ~mem_write_D;
                        mem_addr  <= mem_addr_D;
                        mem_wdata <= mem_wdata_D;
`ifdef MEM_ARB_RR_EN
                        last_d    <= 1'b1;
`endif
                    end else if (req_i) begin
                        state     <= BUSY_I;
                        mem_write <= mem_write_I;
                        mem_read  <= mem_read_I & ~mem_write_I;
                        mem_addr  <= mem_addr_I;
                        mem_wdata <= mem_wdata_I;
`ifdef MEM_ARB_RR_EN
                        last_d    <= 1'b0;
`endif
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        state       <= RESP;
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        mem_rdata_I <= mem_rdata;
                        mem_ready_I <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        state       <= RESP;
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        mem_rdata_D <= mem_rdata;
                        mem_ready_D <= 1'b1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    mem_ready_I <= 1'b0;
                    mem_ready_D <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
